// File: rtl/relay_pkg.sv
// Shared types and defaults for the 4PDT relay model.
package relay_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PULL_IN   = 2'd1,
    ENERGIZED = 2'd2,
    DROP_OUT  = 2'd3
  } relay_state_e;

  localparam int NUM_POLES           = 4;
  localparam int DEF_PULL_IN_CYCLES  = 2;
  localparam int DEF_DROP_OUT_CYCLES = 1;
  localparam int TMR_W               = 8;

endpackage

// File: rtl/relay_contact_bank.sv
// Combinational contact gating: each pole common is routed to at most one throw.
import relay_pkg::*;

module relay_contact_bank #(
  parameter int WIDTH = 1
) (
  input  logic                              connect_hi_i,
  input  logic                              connect_lo_i,
  input  logic [NUM_POLES-1:0][WIDTH-1:0]   in_i,
  output logic [NUM_POLES-1:0][WIDTH-1:0]   hi_o,
  output logic [NUM_POLES-1:0][WIDTH-1:0]   lo_o
);

  for (genvar k = 0; k < NUM_POLES; k++) begin : g_pole
    assign hi_o[k] = in_i[k] & {WIDTH{connect_hi_i}};
    assign lo_o[k] = in_i[k] & {WIDTH{connect_lo_i}};
  end

endmodule

// File: rtl/relay_contact_model.sv
// 4PDT relay: coil FSM with pull-in/drop-out timers, actuation counter, gated contacts.
import relay_pkg::*;

module relay_contact_model #(
  parameter int WIDTH           = 1,
  parameter int PULL_IN_CYCLES  = DEF_PULL_IN_CYCLES,
  parameter int DROP_OUT_CYCLES = DEF_DROP_OUT_CYCLES,
  parameter int ACT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             control,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [WIDTH-1:0] out_hi_0,
  output logic [WIDTH-1:0] out_hi_1,
  output logic [WIDTH-1:0] out_hi_2,
  output logic [WIDTH-1:0] out_hi_3,
  output logic [WIDTH-1:0] out_lo_0,
  output logic [WIDTH-1:0] out_lo_1,
  output logic [WIDTH-1:0] out_lo_2,
  output logic [WIDTH-1:0] out_lo_3,
  output logic             energized,
  output logic             in_transit,
  output logic [ACT_W-1:0] actuations
);

  // Timer counts down to zero; load value is delay-1 so the throw closes on edge N.
  localparam logic [TMR_W-1:0] PI_LOAD = TMR_W'((PULL_IN_CYCLES  > 0) ? PULL_IN_CYCLES  - 1 : 0);
  localparam logic [TMR_W-1:0] DO_LOAD = TMR_W'((DROP_OUT_CYCLES > 0) ? DROP_OUT_CYCLES - 1 : 0);

  relay_state_e     state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic             act_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_inc = 1'b0;
    unique case (state_q)
      RELEASED: if (control) begin
        if (PULL_IN_CYCLES == 0) begin
          state_d = ENERGIZED;
          act_inc = 1'b1;
        end else begin
          state_d = PULL_IN;
          cnt_d   = PI_LOAD;
        end
      end
      PULL_IN: begin
        if (!control) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ENERGIZED;
          act_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ENERGIZED: if (!control) begin
        if (DROP_OUT_CYCLES == 0) begin
          state_d = RELEASED;
        end else begin
          state_d = DROP_OUT;
          cnt_d   = DO_LOAD;
        end
      end
      DROP_OUT: begin
        // A bounce back to 1 recloses the hi throws without counting a new actuation.
        if (control) begin
          state_d = ENERGIZED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
    act_d = (act_inc && (act_q != '1)) ? act_q + ACT_W'(1) : act_q;
  end

  assign energized  = (state_q == ENERGIZED);
  assign in_transit = (state_q == PULL_IN) || (state_q == DROP_OUT);
  assign actuations = act_q;

  logic [NUM_POLES-1:0][WIDTH-1:0] pins, phi, plo;
  assign pins = {in_3, in_2, in_1, in_0};

  relay_contact_bank #(.WIDTH(WIDTH)) u_bank (
    .connect_hi_i (state_q == ENERGIZED),
    .connect_lo_i (state_q == RELEASED),
    .in_i         (pins),
    .hi_o         (phi),
    .lo_o         (plo)
  );

  assign {out_hi_3, out_hi_2, out_hi_1, out_hi_0} = phi;
  assign {out_lo_3, out_lo_2, out_lo_1, out_lo_0} = plo;

endmodule

// File: tb/tb_relay_contact_model.sv
// Bench: three relay configurations driven in parallel, checked against a settle/transit model.
module tb_relay_contact_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       control;
  logic [3:0] in_v;

  logic [3:0]  hi_a, lo_a, hi_b, lo_b, hi_c, lo_c;
  logic        en_a, en_b, en_c, tr_a, tr_b, tr_c;
  logic [15:0] act_a, act_b;
  logic [1:0]  act_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  relay_contact_model #(.WIDTH(1), .PULL_IN_CYCLES(2), .DROP_OUT_CYCLES(1), .ACT_W(16)) u_a (
    .clk(clk), .rst(rst), .control(control),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .out_hi_0(hi_a[0]), .out_hi_1(hi_a[1]), .out_hi_2(hi_a[2]), .out_hi_3(hi_a[3]),
    .out_lo_0(lo_a[0]), .out_lo_1(lo_a[1]), .out_lo_2(lo_a[2]), .out_lo_3(lo_a[3]),
    .energized(en_a), .in_transit(tr_a), .actuations(act_a));

  relay_contact_model #(.WIDTH(1), .PULL_IN_CYCLES(0), .DROP_OUT_CYCLES(0), .ACT_W(16)) u_b (
    .clk(clk), .rst(rst), .control(control),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .out_hi_0(hi_b[0]), .out_hi_1(hi_b[1]), .out_hi_2(hi_b[2]), .out_hi_3(hi_b[3]),
    .out_lo_0(lo_b[0]), .out_lo_1(lo_b[1]), .out_lo_2(lo_b[2]), .out_lo_3(lo_b[3]),
    .energized(en_b), .in_transit(tr_b), .actuations(act_b));

  relay_contact_model #(.WIDTH(1), .PULL_IN_CYCLES(1), .DROP_OUT_CYCLES(2), .ACT_W(2)) u_c (
    .clk(clk), .rst(rst), .control(control),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .out_hi_0(hi_c[0]), .out_hi_1(hi_c[1]), .out_hi_2(hi_c[2]), .out_hi_3(hi_c[3]),
    .out_lo_0(lo_c[0]), .out_lo_1(lo_c[1]), .out_lo_2(lo_c[2]), .out_lo_3(lo_c[3]),
    .energized(en_c), .in_transit(tr_c), .actuations(act_c));

  // Reference: a relay is either settled at a position, or in transit toward the
  // other one with some edges left; a sampled control matching the settled
  // position cancels the transit.
  int pd[3]   = '{2, 0, 1};
  int dd[3]   = '{1, 0, 2};
  int amax[3] = '{65535, 65535, 3};
  bit m_set[3];
  bit m_tr[3];
  int m_left[3];
  int m_act[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_set[i] <= 1'b0; m_tr[i] <= 1'b0; m_left[i] <= 0; m_act[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit s = m_set[i];
        automatic bit t = m_tr[i];
        automatic int l = m_left[i];
        automatic int a = m_act[i];
        automatic bit c = control;
        automatic int d = c ? pd[i] : dd[i];
        if (!t) begin
          if (c != s) begin
            if (d == 0) begin
              s = c;
              if (c && a < amax[i]) a = a + 1;
            end else begin
              t = 1'b1; l = d;
            end
          end
        end else if (c == s) begin
          t = 1'b0;
        end else begin
          l = l - 1;
          if (l == 0) begin
            s = c; t = 1'b0;
            if (c && a < amax[i]) a = a + 1;
          end
        end
        m_set[i] <= s; m_tr[i] <= t; m_left[i] <= l; m_act[i] <= a;
      end
    end
  end

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  logic [3:0]  g_hi[3], g_lo[3];
  logic        g_en[3], g_tr[3];
  logic [15:0] g_act[3];
  assign g_hi[0] = hi_a;  assign g_hi[1] = hi_b;  assign g_hi[2] = hi_c;
  assign g_lo[0] = lo_a;  assign g_lo[1] = lo_b;  assign g_lo[2] = lo_c;
  assign g_en[0] = en_a;  assign g_en[1] = en_b;  assign g_en[2] = en_c;
  assign g_tr[0] = tr_a;  assign g_tr[1] = tr_b;  assign g_tr[2] = tr_c;
  assign g_act[0] = act_a; assign g_act[1] = act_b; assign g_act[2] = {14'd0, act_c};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic bit closed_hi = m_set[i] && !m_tr[i];
      automatic bit closed_lo = !m_set[i] && !m_tr[i];
      cmp($sformatf("u%0d.out_hi", i), 16'(g_hi[i]), closed_hi ? 16'(in_v) : 16'd0);
      cmp($sformatf("u%0d.out_lo", i), 16'(g_lo[i]), closed_lo ? 16'(in_v) : 16'd0);
      cmp($sformatf("u%0d.energized", i), 16'(g_en[i]), 16'(closed_hi));
      cmp($sformatf("u%0d.in_transit", i), 16'(g_tr[i]), 16'(m_tr[i]));
      cmp($sformatf("u%0d.actuations", i), g_act[i], 16'(m_act[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; control = 1'b0; in_v = 4'b1101;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    cmp("rst_lo", 16'(lo_a), 16'hd);
    cmp("rst_hi", 16'(hi_a), 16'h0);
    cmp("rst_act", act_a, 16'd0);

    // Pull-in with defaults: closes on the third edge after control rises.
    control = 1'b1;
    step();
    cmp("pi_transit", 16'(tr_a), 16'd1);
    cmp("pi_open", 16'({hi_a, lo_a}), 16'h0);
    step();
    step();
    cmp("pi_energized", 16'(en_a), 16'd1);
    cmp("pi_hi", 16'(hi_a), 16'hd);
    cmp("pi_lo", 16'(lo_a), 16'h0);
    cmp("pi_act", act_a, 16'd1);

    // Data path is transparent within the cycle.
    in_v = 4'b1001;
    #1 cmp("xp_hi0", 16'(hi_a), 16'h9);
    in_v[2] = 1'b1;
    #1 cmp("xp_hi2", 16'(hi_a[2]), 16'd1);
    in_v = 4'b1101;

    // Drop-out: one open cycle, then lo throws close.
    control = 1'b0;
    step();
    cmp("do_open", 16'({hi_a, lo_a}), 16'h0);
    step();
    cmp("do_lo", 16'(lo_a), 16'hd);
    cmp("do_en", 16'(en_a), 16'd0);

    // One-cycle pulse in RELEASED aborts the pull-in.
    control = 1'b1;
    step();
    control = 1'b0;
    step();
    cmp("ab_lo", 16'(lo_a), 16'hd);
    cmp("ab_tr", 16'(tr_a), 16'd0);
    step(); step();
    cmp("ab_act", act_a, 16'd1);

    // 0-glitch in ENERGIZED bounces back without a new actuation.
    control = 1'b1;
    repeat (3) step();
    cmp("gl_pre_act", act_a, 16'd2);
    control = 1'b0;
    step();
    control = 1'b1;
    step();
    cmp("gl_en", 16'(en_a), 16'd1);
    cmp("gl_act", act_a, 16'd2);

    // Zero-delay instance swaps on the sampling edge with no transit.
    control = 1'b0;
    step();
    cmp("z_lo", 16'(lo_b), 16'hd);
    cmp("z_tr", 16'(tr_b), 16'd0);
    control = 1'b1;
    step();
    cmp("z_hi", 16'(hi_b), 16'hd);
    cmp("z_tr2", 16'(tr_b), 16'd0);
    repeat (2) step();

    // Asynchronous reset mid-ENERGIZED takes effect immediately.
    cmp("pre_rst_en", 16'(en_a), 16'd1);
    rst = 1'b1;
    control = 1'b0;
    #1;
    cmp("arst_lo", 16'(lo_a), 16'hd);
    cmp("arst_hi", 16'(hi_a), 16'h0);
    cmp("arst_en", 16'(en_a), 16'd0);
    cmp("arst_act", act_a, 16'd0);
    step();
    rst = 1'b0;
    step();

    // Five full cycles: 2-bit counter saturates at 3.
    repeat (5) begin
      control = 1'b1;
      repeat (3) step();
      control = 1'b0;
      repeat (4) step();
    end
    cmp("sat_c", 16'(act_c), 16'd3);
    cmp("sat_a", act_a, 16'd5);

    // Randomized control dwell times and pole data, with occasional resets.
    repeat (150) begin
      control = 1'($urandom_range(0, 1));
      in_v = 4'($urandom);
      repeat ($urandom_range(1, 5)) begin
        step();
        if ($urandom_range(0, 2) == 0) in_v = 4'($urandom);
      end
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/relay_contact_model.md
Name: relay_contact_model

Overview:
- Cycle-accurate synchronous model of a 4-pole double-throw (4PDT) electromechanical relay. It is the basic switching element of the relay computer's ALU, adder, and register blocks.
- A coil input `control` selects which throw each pole's input is routed to: the `out_lo_*` throws when released, the `out_hi_*` throws when energized.
- Pull-in and drop-out are modelled as programmable mechanical delays, with break-before-make contact behaviour.

Parameters:
- WIDTH, 1: bit width of each pole (each input and output port).
- PULL_IN_CYCLES, 2: cycles from sampled control=1 until the hi throws close. Range 0..255.
- DROP_OUT_CYCLES, 1: cycles from sampled control=0 until the lo throws close. Range 0..255.
- ACT_W, 16: width of the actuation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- control  in  1  coil drive; sampled on clk.
- in_0..in_3  in  WIDTH each  pole commons.
- out_hi_0..out_hi_3  out  WIDTH each  normally-open throws; equal in_k when energized, else 0.
- out_lo_0..out_lo_3  out  WIDTH each  normally-closed throws; equal in_k when released, else 0.
- energized  out  1  high in the ENERGIZED state.
- in_transit  out  1  high in the PULL_IN or DROP_OUT state (all contacts open).
- actuations  out  ACT_W  count of completed pull-ins; saturates at all-ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- States (registered): RELEASED, PULL_IN, ENERGIZED, DROP_OUT. A down-counter (8 bits) times the transit states.
- Data path is combinational. Outputs are in_k ANDed with the registered connect-hi or connect-lo enable, so there is zero latency from in_k to its outputs. Only control has latency.
- Contact mapping by state:
  - RELEASED: out_lo_k = in_k; out_hi_k = 0.
  - ENERGIZED: out_hi_k = in_k; out_lo_k = 0.
  - PULL_IN and DROP_OUT: all out_hi_k and out_lo_k = 0 (break-before-make). No cycle ever has both throws of a pole connected.
- RELEASED with control=1 sampled:
  - If PULL_IN_CYCLES=0, go to ENERGIZED directly.
  - Otherwise go to PULL_IN, load the counter with PULL_IN_CYCLES-1.
- PULL_IN:
  - control=0 sampled: abort to RELEASED next edge; actuations is not incremented.
  - Counter=0: go to ENERGIZED and increment actuations.
  - Otherwise decrement the counter.
  - Net effect: the hi throws close exactly PULL_IN_CYCLES edges after the sampling edge.
- ENERGIZED with control=0 sampled:
  - If DROP_OUT_CYCLES=0, go to RELEASED directly.
  - Otherwise go to DROP_OUT, load the counter with DROP_OUT_CYCLES-1.
- DROP_OUT:
  - control=1 sampled: return to ENERGIZED next edge; this is not a new actuation.
  - Counter=0: go to RELEASED.
  - Otherwise decrement the counter.
- A direct RELEASED to ENERGIZED transition (PULL_IN_CYCLES=0) also increments actuations.
- actuations saturates at 2^ACT_W-1 and never wraps.
- Reset, at power-up or mid-operation: immediately state=RELEASED, counter=0, actuations=0. Consequently out_lo_k = in_k, out_hi_k = 0, energized=0, in_transit=0 while rst is high and after release.
- control is held steady: no transition occurs without a sampled level change.

Decomposition:
- Package relay_pkg holds:
  - the typedef enum relay_state_e {RELEASED, PULL_IN, ENERGIZED, DROP_OUT};
  - the default delay constants;
  - a localparam for NUM_POLES=4.
- Sub-module relay_contact_bank is combinational only. It takes the connect_hi and connect_lo enables plus the 4 pole inputs and produces the 8 gated outputs.
- The top level holds the FSM, the timer, and the counter.

Test Plan:
- Reset and release: in_0..3=1,0,1,1; rst pulsed mid-ENERGIZED -> immediately out_lo=1,0,1,1, out_hi all 0, energized=0, actuations=0.
- Pull-in timing (defaults): control=1 sampled at edge 1 -> after edge 1 in_transit=1 and all outputs 0; after edge 3 energized=1, out_hi_k=in_k, out_lo all 0, actuations=1.
- Drop-out timing: control=0 sampled at edge n in ENERGIZED -> outputs open for 1 cycle; after edge n+1 out_lo_k=in_k, energized=0.
- Abort and bounce:
  - control pulse of 1 cycle in RELEASED -> PULL_IN then back to RELEASED; hi throws never close; actuations unchanged.
  - control 0-glitch in ENERGIZED -> back to ENERGIZED; actuations unchanged.
- Zero delays (PULL_IN_CYCLES=0, DROP_OUT_CYCLES=0): toggling control -> throws swap on the sampling edge; in_transit stays 0.
- Data transparency and saturation:
  - Change in_2 0->1 while ENERGIZED -> out_hi_2=1 the same cycle.
  - With ACT_W=2, 5 pull-ins -> actuations=3.
